// File: rtl/score_board_ctrl.sv
// score_board_ctrl
//   High-score manager. Keeps a TOP_K-deep leaderboard, sorted ascending by
//   score (lower is better), and one personal-best word per user in an
//   external single-port synchronous RAM with RD_LAT cycles of read latency.
//
//   RAM map: 0..TOP_K-1 leaderboard, TOP_K+u personal best of user u.
//   Word layout: {id, score}; score all-ones means "empty".
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-low reset
//   cmd_valid/ready    command handshake (ready only while idle)
//   cmd_op             0 SUBMIT, 1 READ, 2 CLEAR, 3 reserved (error)
//   cmd_guest          SUBMIT: guest play, never stored
//   cmd_user           personal-best slot
//   cmd_pid/score      player ID and score for SUBMIT
//   cmd_rank           READ index (0 = best)
//   ram_we/addr/din    RAM request (ram_we=1 write, 0 read)
//   ram_dout           RAM read data, valid RD_LAT cycles after the address
//   rsp_valid          one-cycle completion pulse
//   rsp_err/pb/rank    completion status, held until the next acceptance
//   rd_id/rd_score     READ result, held until the next READ completes
//   dbg_state          current FSM state
//
// Handshake: a command is taken on a rising edge where cmd_valid && cmd_ready;
// all command fields are registered at that edge and may change afterwards.
// The host must not rely on anything but rsp_valid to know it is finished.
//
// SUBMIT path: read PB slot, optionally write it, scan the board from index 0
// for the first strictly slower entry p, shift p..TOP_K-2 down by one (reading
// from the bottom up so nothing is overwritten before it is moved), then write
// the new entry at p. A bubble cycle separates the last shift write from the
// insert write so ram_we is never high on two consecutive cycles there.
module score_board_ctrl #(
  parameter int SCORE_W   = 8,
  parameter int ID_W      = 16,
  parameter int NUM_USERS = 8,
  parameter int TOP_K     = 4,
  parameter int RD_LAT    = 3,
  parameter int ADDR_W    = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic                          cmd_guest,
  input  logic [$clog2(NUM_USERS)-1:0]  cmd_user,
  input  logic [ID_W-1:0]               cmd_pid,
  input  logic [SCORE_W-1:0]            cmd_score,
  input  logic [$clog2(TOP_K)-1:0]      cmd_rank,
  output logic                          ram_we,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [ID_W+SCORE_W-1:0]       ram_din,
  input  logic [ID_W+SCORE_W-1:0]       ram_dout,
  output logic                          rsp_valid,
  output logic                          rsp_err,
  output logic                          rsp_pb,
  output logic [$clog2(TOP_K+1)-1:0]    rsp_rank,
  output logic [ID_W-1:0]               rd_id,
  output logic [SCORE_W-1:0]            rd_score,
  output logic [3:0]                    dbg_state
);

  localparam int USER_W = $clog2(NUM_USERS);
  localparam int RANK_W = $clog2(TOP_K);
  localparam int RSP_W  = $clog2(TOP_K + 1);
  localparam int WORD_W = ID_W + SCORE_W;
  localparam int CNT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [ADDR_W-1:0]  ONE_A       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0]  LB_LAST     = ADDR_W'(TOP_K - 1);
  localparam logic [ADDR_W-1:0]  SH_FIRST    = ADDR_W'(TOP_K - 2);
  localparam logic [ADDR_W-1:0]  PB_BASE     = ADDR_W'(TOP_K);
  localparam logic [ADDR_W-1:0]  CLR_LAST    = ADDR_W'(TOP_K + NUM_USERS - 1);
  localparam logic [CNT_W-1:0]   WAIT_LAST   = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0]   ONE_C       = CNT_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_EMPTY = '1;
  localparam logic [RSP_W-1:0]   NOT_PLACED  = RSP_W'(TOP_K);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    CLR     = 4'd1,
    PB_RD   = 4'd2,
    PB_WAIT = 4'd3,
    PB_CHK  = 4'd4,
    PB_WR   = 4'd5,
    LB_RD   = 4'd6,
    LB_WAIT = 4'd7,
    LB_CHK  = 4'd8,
    SH_RD   = 4'd9,
    SH_WAIT = 4'd10,
    SH_WR   = 4'd11,
    INS_WR  = 4'd12,
    RD_RD   = 4'd13,
    RD_WAIT = 4'd14,
    DONE    = 4'd15
  } stateT;

  stateT state, stateNext;

  // captured command
  logic [USER_W-1:0]  userQ;
  logic [ID_W-1:0]    pidQ;
  logic [SCORE_W-1:0] scoreQ;
  logic [RANK_W-1:0]  rankQ;

  // walk state
  logic [CNT_W-1:0]   waitCnt;
  logic [ADDR_W-1:0]  idx;      // clear address, scan index or shift source
  logic [ADDR_W-1:0]  pos;      // insert position p
  logic [WORD_W-1:0]  dataQ;    // last word read from RAM
  logic               insArm;   // insert write may fire this cycle

  // response registers
  logic               rspErrQ;
  logic               rspPbQ;
  logic [RSP_W-1:0]   rspRankQ;
  logic [ID_W-1:0]    rdIdQ;
  logic [SCORE_W-1:0] rdScoreQ;

  logic               userBad;
  logic               rankBad;
  logic               waitDone;
  logic               better;
  logic [ADDR_W-1:0]  pbAddr;

  assign userBad  = {{(32-USER_W){1'b0}}, cmd_user} >= 32'(NUM_USERS);
  assign rankBad  = {{(32-RANK_W){1'b0}}, cmd_rank} >= 32'(TOP_K);
  assign waitDone = (waitCnt == WAIT_LAST);
  // strict unsigned compare: ties rank below the stored word
  assign better   = (scoreQ < dataQ[SCORE_W-1:0]);
  assign pbAddr   = PB_BASE + ADDR_W'(userQ);

  assign rsp_err   = rspErrQ;
  assign rsp_pb    = rspPbQ;
  assign rsp_rank  = rspRankQ;
  assign rd_id     = rdIdQ;
  assign rd_score  = rdScoreQ;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    cmd_ready = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_din   = '0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (cmd_op)
            2'd0:    stateNext = (cmd_guest || userBad) ? DONE : PB_RD;
            2'd1:    stateNext = rankBad ? DONE : RD_RD;
            2'd2:    stateNext = CLR;
            default: stateNext = DONE;
          endcase
        end
      end
      CLR: begin
        ram_we   = 1'b1;
        ram_addr = idx;
        ram_din  = {{ID_W{1'b0}}, SCORE_EMPTY};
        if (idx == CLR_LAST) stateNext = DONE;
      end
      PB_RD: begin
        ram_addr  = pbAddr;
        stateNext = PB_WAIT;
      end
      PB_WAIT: begin
        ram_addr = pbAddr;
        if (waitDone) stateNext = PB_CHK;
      end
      PB_CHK: begin
        stateNext = better ? PB_WR : LB_RD;
      end
      PB_WR: begin
        ram_we    = 1'b1;
        ram_addr  = pbAddr;
        ram_din   = {pidQ, scoreQ};
        stateNext = LB_RD;
      end
      LB_RD: begin
        ram_addr  = idx;
        stateNext = LB_WAIT;
      end
      LB_WAIT: begin
        ram_addr = idx;
        if (waitDone) stateNext = LB_CHK;
      end
      LB_CHK: begin
        if (better)                stateNext = (idx == LB_LAST) ? INS_WR : SH_RD;
        else if (idx == LB_LAST)   stateNext = DONE;
        else                       stateNext = LB_RD;
      end
      SH_RD: begin
        ram_addr  = idx;
        stateNext = SH_WAIT;
      end
      SH_WAIT: begin
        ram_addr = idx;
        if (waitDone) stateNext = SH_WR;
      end
      SH_WR: begin
        ram_we    = 1'b1;
        ram_addr  = idx + ONE_A;
        ram_din   = dataQ;
        stateNext = (idx == pos) ? INS_WR : SH_RD;
      end
      INS_WR: begin
        ram_we   = insArm;
        ram_addr = pos;
        ram_din  = {pidQ, scoreQ};
        if (insArm) stateNext = DONE;
      end
      RD_RD: begin
        ram_addr  = ADDR_W'(rankQ);
        stateNext = RD_WAIT;
      end
      RD_WAIT: begin
        ram_addr = ADDR_W'(rankQ);
        if (waitDone) stateNext = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      userQ    <= '0;
      pidQ     <= '0;
      scoreQ   <= '0;
      rankQ    <= '0;
      waitCnt  <= '0;
      idx      <= '0;
      pos      <= '0;
      dataQ    <= '0;
      insArm   <= 1'b0;
      rspErrQ  <= 1'b0;
      rspPbQ   <= 1'b0;
      rspRankQ <= '0;
      rdIdQ    <= '0;
      rdScoreQ <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            userQ    <= cmd_user;
            pidQ     <= cmd_pid;
            scoreQ   <= cmd_score;
            rankQ    <= cmd_rank;
            rspErrQ  <= (cmd_op == 2'd3) ||
                        ((cmd_op == 2'd0) && userBad) ||
                        ((cmd_op == 2'd1) && rankBad);
            rspPbQ   <= 1'b0;
            rspRankQ <= NOT_PLACED;
            idx      <= '0;
            waitCnt  <= '0;
          end
        end
        CLR: idx <= idx + ONE_A;
        PB_RD, LB_RD, SH_RD, RD_RD: waitCnt <= '0;
        PB_WAIT, LB_WAIT, SH_WAIT: begin
          if (waitDone) begin
            dataQ   <= ram_dout;
            waitCnt <= '0;
          end else begin
            waitCnt <= waitCnt + ONE_C;
          end
        end
        RD_WAIT: begin
          if (waitDone) begin
            rdIdQ    <= ram_dout[WORD_W-1:SCORE_W];
            rdScoreQ <= ram_dout[SCORE_W-1:0];
            waitCnt  <= '0;
          end else begin
            waitCnt <= waitCnt + ONE_C;
          end
        end
        PB_CHK: idx <= '0;
        PB_WR: begin
          rspPbQ <= 1'b1;
          idx    <= '0;
        end
        LB_CHK: begin
          if (better) begin
            pos <= idx;
            // inserting at the last slot needs no shift, so no bubble either
            insArm <= (idx == LB_LAST);
            if (idx != LB_LAST) idx <= SH_FIRST;
          end else if (idx != LB_LAST) begin
            idx <= idx + ONE_A;
          end
        end
        SH_WR: begin
          if (idx != pos) idx <= idx - ONE_A;
        end
        INS_WR: begin
          insArm <= 1'b1;
          if (insArm) rspRankQ <= RSP_W'(pos);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_score_board_ctrl.sv
module tb_score_board_ctrl;
  localparam int SCORE_W   = 8;
  localparam int ID_W      = 16;
  localparam int NUM_USERS = 8;
  localparam int TOP_K     = 4;
  localparam int RD_LAT    = 3;
  localparam int ADDR_W    = 5;
  localparam int WORD_W    = ID_W + SCORE_W;
  localparam int R         = RD_LAT + 1;
  localparam int EW        = 3 + 3 + WORD_W;  // {chk, err, pb, rank, id, score}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = '0;
  logic              cmd_guest = 1'b0;
  logic [2:0]        cmd_user = '0;
  logic [ID_W-1:0]   cmd_pid = '0;
  logic [SCORE_W-1:0] cmd_score = '0;
  logic [1:0]        cmd_rank = '0;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [WORD_W-1:0] ram_din;
  logic [WORD_W-1:0] ram_dout;
  logic              rsp_valid, rsp_err, rsp_pb;
  logic [2:0]        rsp_rank;
  logic [ID_W-1:0]   rd_id;
  logic [SCORE_W-1:0] rd_score;
  logic [3:0]        dbg_state;

  score_board_ctrl #(
    .SCORE_W(SCORE_W), .ID_W(ID_W), .NUM_USERS(NUM_USERS),
    .TOP_K(TOP_K), .RD_LAT(RD_LAT), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_guest(cmd_guest), .cmd_user(cmd_user), .cmd_pid(cmd_pid),
    .cmd_score(cmd_score), .cmd_rank(cmd_rank),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_pb(rsp_pb), .rsp_rank(rsp_rank),
    .rd_id(rd_id), .rd_score(rd_score), .dbg_state(dbg_state)
  );

  // ---------------- RAM model ----------------
  logic [WORD_W-1:0] mem  [0:(1<<ADDR_W)-1];
  logic [WORD_W-1:0] pipe [0:RD_LAT-1];
  int we_cycles = 0;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    pipe[0] <= mem[ram_addr];
    for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
    if (ram_we) we_cycles <= we_cycles + 1;
  end
  assign ram_dout = pipe[RD_LAT-1];

  // ---------------- reference model + scoreboard ----------------
  logic [WORD_W-1:0]  lb_q[$];
  logic [SCORE_W-1:0] pb_score [NUM_USERS];
  logic [ID_W-1:0]    pb_id    [NUM_USERS];
  logic [WORD_W-1:0]  last_rd = '0;
  logic [EW-1:0]      exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] pack(input logic chk, input logic err, input logic pb,
                                         input logic [2:0] rank, input logic [WORD_W-1:0] rd);
    return {chk, err, pb, rank, rd};
  endfunction

  function automatic void model_clear();
    lb_q = {};
    for (int i = 0; i < TOP_K; i++) lb_q.push_back({{ID_W{1'b0}}, 8'hFF});
    for (int u = 0; u < NUM_USERS; u++) begin
      pb_score[u] = 8'hFF;
      pb_id[u]    = '0;
    end
    exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 3'd0, last_rd));
  endfunction

  function automatic void model_submit(input logic g, input int user, input logic [ID_W-1:0] pid,
                                       input logic [SCORE_W-1:0] score);
    int p;
    logic pb;
    if (g || user >= NUM_USERS) begin
      exp_q.push_back(pack(1'b1, user >= NUM_USERS, 1'b0, 3'(TOP_K), last_rd));
      return;
    end
    pb = score < pb_score[user];
    if (pb) begin
      pb_score[user] = score;
      pb_id[user]    = pid;
    end
    p = TOP_K;
    for (int i = TOP_K - 1; i >= 0; i--)
      if (score < lb_q[i][SCORE_W-1:0]) p = i;
    if (p < TOP_K) begin
      lb_q.insert(p, {pid, score});
      void'(lb_q.pop_back());
    end
    exp_q.push_back(pack(1'b1, 1'b0, pb, 3'(p), last_rd));
  endfunction

  function automatic void model_read(input int rank);
    last_rd = lb_q[rank];
    exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 3'd0, last_rd));
  endfunction

  // monitor: pops one expectation per completion pulse
  always @(negedge clk) begin
    if (rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: got rsp_valid expected none (t=%0t)", $time);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("rsp_err", rsp_err, e[EW-2]);
        if (e[EW-1]) begin
          check("rsp_pb", rsp_pb, e[EW-3]);
          check("rsp_rank", rsp_rank, e[WORD_W+2:WORD_W]);
        end
        check("rd_id", rd_id, e[WORD_W-1:SCORE_W]);
        check("rd_score", rd_score, e[SCORE_W-1:0]);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_cmd(input logic [1:0] op, input logic g, input logic [2:0] user,
                        input logic [ID_W-1:0] pid, input logic [SCORE_W-1:0] score,
                        input logic [1:0] rank, input int exp_lat,
                        output logic [2:0] got_rank, output logic got_pb, output int lat);
    int n;
    case (op)
      2'd0:    model_submit(g, int'(user), pid, score);
      2'd1:    model_read(int'(rank));
      2'd2:    model_clear();
      default: exp_q.push_back(pack(1'b1, 1'b1, 1'b0, 3'(TOP_K), last_rd));
    endcase
    @(negedge clk);
    cmd_op = op; cmd_guest = g; cmd_user = user; cmd_pid = pid;
    cmd_score = score; cmd_rank = rank; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    // scramble fields to confirm they were captured at acceptance
    cmd_op = 2'($urandom); cmd_guest = 1'($urandom); cmd_user = 3'($urandom);
    cmd_pid = ID_W'($urandom); cmd_score = 8'($urandom); cmd_rank = 2'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 500);
    if (!rsp_valid) begin
      check("rsp_timeout", 32'(rsp_valid), 32'd1);
      exp_q.delete();
    end
    if (exp_lat > 0) check("latency", lat, exp_lat);
    got_rank = rsp_rank;
    got_pb   = rsp_pb;
  endtask

  logic [2:0] g_rank;
  logic       g_pb;
  int         g_lat;

  task automatic submit(input logic g, input logic [2:0] user, input logic [ID_W-1:0] pid,
                        input logic [SCORE_W-1:0] score);
    do_cmd(2'd0, g, user, pid, score, 2'd0, g ? 1 : 0, g_rank, g_pb, g_lat);
  endtask

  task automatic read_rank(input logic [1:0] rank);
    do_cmd(2'd1, 1'b0, 3'd0, '0, '0, rank, R + 1, g_rank, g_pb, g_lat);
  endtask

  task automatic clear_all();
    do_cmd(2'd2, 1'b0, 3'd0, '0, '0, 2'd0, TOP_K + NUM_USERS + 1, g_rank, g_pb, g_lat);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  logic [ID_W-1:0]    exp_ids [4];
  logic [SCORE_W-1:0] exp_scs [4];

  initial begin
    int wec0, n;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_ram_we", ram_we, 1'b0);
    check("rst_ram_addr", ram_addr, '0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rank", rsp_rank, '0);
    check("rst_rd_score", rd_score, '0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b1);

    // bring-up
    clear_all();
    for (int r = 0; r < TOP_K; r++) begin
      read_rank(2'(r));
      check("bringup_id", rd_id, 16'h0);
      check("bringup_score", rd_score, 8'hFF);
    end

    // insertion order
    submit(1'b0, 3'd0, 16'h1111, 8'd40); check("ins_rank_a", g_rank, 3'd0);
    submit(1'b0, 3'd1, 16'h2222, 8'd20); check("ins_rank_b", g_rank, 3'd0);
    submit(1'b0, 3'd2, 16'h3333, 8'd30); check("ins_rank_c", g_rank, 3'd1);
    exp_ids = '{16'h2222, 16'h3333, 16'h1111, 16'h0};
    exp_scs = '{8'd20, 8'd30, 8'd40, 8'd255};
    for (int r = 0; r < TOP_K; r++) begin
      read_rank(2'(r));
      check("ins_read_id", rd_id, exp_ids[r]);
      check("ins_read_score", rd_score, exp_scs[r]);
    end

    // tie and overflow
    clear_all();
    submit(1'b0, 3'd0, 16'hA010, 8'd10);
    submit(1'b0, 3'd1, 16'hA020, 8'd20);
    submit(1'b0, 3'd2, 16'hA030, 8'd30);
    submit(1'b0, 3'd3, 16'hA040, 8'd40);
    submit(1'b0, 3'd4, 16'hB020, 8'd20); check("tie_rank", g_rank, 3'd2);
    submit(1'b0, 3'd5, 16'hB050, 8'd50); check("overflow_rank", g_rank, 3'd4);
    exp_ids = '{16'hA010, 16'hA020, 16'hB020, 16'hA030};
    exp_scs = '{8'd10, 8'd20, 8'd20, 8'd30};
    for (int r = 0; r < TOP_K; r++) begin
      read_rank(2'(r));
      check("tie_read_id", rd_id, exp_ids[r]);
      check("tie_read_score", rd_score, exp_scs[r]);
    end

    // personal best
    clear_all();
    submit(1'b0, 3'd3, 16'h0C03, 8'd25); check("pb_first", g_pb, 1'b1);
    submit(1'b0, 3'd3, 16'h0C03, 8'd35); check("pb_second", g_pb, 1'b0);
    check("pb_word", mem[TOP_K + 3], {16'h0C03, 8'd25});
    submit(1'b0, 3'd0, 16'h0C00, 8'd10);
    submit(1'b0, 3'd1, 16'h0C01, 8'd12);
    submit(1'b0, 3'd3, 16'h0C03, 8'd35);
    check("pb_scan_rank", g_rank, 3'd4);
    check("pb_scan_pb", g_pb, 1'b0);
    check("pb_scan_long", 32'(g_lat >= (TOP_K + 1) * R), 32'd1);
    for (int r = 0; r < TOP_K; r++) read_rank(2'(r));

    // guest and error
    wec0 = we_cycles;
    submit(1'b1, 3'd2, 16'h6666, 8'd5);
    check("guest_rank", g_rank, 3'd4);
    check("guest_no_write", we_cycles, wec0);
    do_cmd(2'd3, 1'b0, 3'd0, '0, '0, 2'd0, 1, g_rank, g_pb, g_lat);
    check("op3_err", rsp_err, 1'b1);

    // randomized traffic
    clear_all();
    for (int i = 0; i < 80; i++) begin
      int sel;
      sel = $urandom_range(0, 19);
      if (sel < 13)
        submit($urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)),
               ID_W'($urandom), 8'($urandom_range(0, 255)));
      else if (sel < 18)
        read_rank(2'($urandom_range(0, 3)));
      else if (sel == 18)
        do_cmd(2'd3, 1'b0, 3'd0, '0, '0, 2'd0, 1, g_rank, g_pb, g_lat);
      else
        clear_all();
    end

    // reset in the middle of a shift
    clear_all();
    submit(1'b0, 3'd0, 16'hD010, 8'd10);
    submit(1'b0, 3'd1, 16'hD020, 8'd20);
    submit(1'b0, 3'd2, 16'hD030, 8'd30);
    submit(1'b0, 3'd3, 16'hD040, 8'd40);
    @(negedge clk);
    cmd_op = 2'd0; cmd_guest = 1'b0; cmd_user = 3'd4; cmd_pid = 16'hD005;
    cmd_score = 8'd5; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dbg_state != 4'd11 && n < 300);
    check("shift_reached", 32'(dbg_state == 4'd11), 32'd1);
    check("shift_we_high", ram_we, 1'b1);
    rst = 1'b0;
    #1;
    check("midrst_we_drop", ram_we, 1'b0);
    check("midrst_no_rsp", rsp_valid, 1'b0);
    last_rd = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready", cmd_ready, 1'b1);
    clear_all();
    for (int r = 0; r < TOP_K; r++) begin
      read_rank(2'(r));
      check("midrst_id", rd_id, 16'h0);
      check("midrst_score", rd_score, 8'hFF);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
